banco_regs_param: RTL

Parametrised two-read/two-write register bank for the image-filter datapath, successor to the fixed 16×32 bank. Scalar port C writes whole words; vector port V writes with per-byte lane enables. Synchronous reads with optional write-through bypass, a same-address write priority rule, a bank-wide clear and async reset. The bank sits between the decode stage (addresses) and the ALU/pixel units (operands A/B).

---
 rtl/banco_regs_param.sv | 97 +++++++++
 1 files changed

// File: rtl/banco_regs_param.sv
// banco_regs_param: parametrised register bank with two read ports (A, B)
// and two write ports (C whole-word, V byte-lane). Reads are registered.
// When BYPASS=1, a read sees the word being written in that same cycle.
// WIDTH must be a multiple of 8. DEPTH must be a power of two (2..256).
module banco_regs_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 we_c,
    input  logic [ADDR_W-1:0]    dir_c,
    input  logic [WIDTH-1:0]     din_c,
    input  logic                 we_v,
    input  logic [WIDTH/8-1:0]   be_v,
    input  logic [ADDR_W-1:0]    dir_v,
    input  logic [WIDTH-1:0]     din_v,
    input  logic                 re_a,
    input  logic                 re_b,
    input  logic [ADDR_W-1:0]    dir_a,
    input  logic [ADDR_W-1:0]    dir_b,
    output logic [WIDTH-1:0]     do_a,
    output logic [WIDTH-1:0]     do_b,
    output logic                 wr_conflict
);

    localparam int LANES = WIDTH / 8;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] do_a_q, do_a_d;
    logic [WIDTH-1:0] do_b_q, do_b_d;
    logic             wr_conflict_q, wr_conflict_d;

    // Next register contents. Port C is applied first, then the enabled V lanes
    // overlay it, so that a same-address collision lets V win on its own lanes.
    // A clear overrides both writes.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
            if (we_c && (dir_c == ADDR_W'(r))) begin
                regs_d[r] = din_c;
            end
            if (we_v && (dir_v == ADDR_W'(r))) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be_v[i]) begin
                        regs_d[r][8*i +: 8] = din_v[8*i +: 8];
                    end
                end
            end
            if (clr) begin
                regs_d[r] = '0;
            end
        end
    end

    // Read muxes. With bypass the source is the next-state word, which already
    // includes any merged write or clear from this cycle. A disabled port holds.
    always_comb begin
        do_a_d = do_a_q;
        do_b_d = do_b_q;
        if (re_a) begin
            do_a_d = BYPASS ? regs_d[dir_a] : regs_q[dir_a];
        end
        if (re_b) begin
            do_b_d = BYPASS ? regs_d[dir_b] : regs_q[dir_b];
        end
        wr_conflict_d = we_c && we_v && (dir_c == dir_v);
    end

    // State registers. An asynchronous reset wipes storage and outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            do_a_q        <= '0;
            do_b_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            do_a_q        <= do_a_d;
            do_b_q        <= do_b_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign do_a        = do_a_q;
    assign do_b        = do_b_q;
    assign wr_conflict = wr_conflict_q;

endmodule
